// File: rtl/reg_file_decoded.sv
// Register file with one decoded write port, two combinational read ports,
// optional hardwired-zero register 0, optional write-to-read bypass and dirty tracking.
module reg_file_decoded #(
  parameter int REGNUM   = 32,
  parameter int WIDTH    = 32,
  parameter int KEY_LEN  = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wen,
  input  logic [KEY_LEN-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [KEY_LEN-1:0] raddr1,
  input  logic [KEY_LEN-1:0] raddr2,
  output logic [WIDTH-1:0]   rdata1,
  output logic [WIDTH-1:0]   rdata2,
  output logic [REGNUM-1:0]  write_onehot,
  output logic [REGNUM-1:0]  last_wr_onehot,
  input  logic               clr_dirty,
  output logic [REGNUM-1:0]  dirty
);

  logic [WIDTH-1:0]  mem_q [REGNUM];
  logic [REGNUM-1:0] dirty_q, dirty_d;
  logic [REGNUM-1:0] last_q, last_d;

  // Out-of-range and hardwired-zero indices never decode, so they drop silently.
  always_comb begin
    write_onehot = '0;
    for (int i = 0; i < REGNUM; i++) begin
      if (wen && (waddr == KEY_LEN'(i)) && !(ZERO_REG && (i == 0)))
        write_onehot[i] = 1'b1;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [KEY_LEN-1:0] addr);
    logic [WIDTH-1:0] val;
    val = '0;
    for (int i = 0; i < REGNUM; i++) begin
      if ((addr == KEY_LEN'(i)) && !(ZERO_REG && (i == 0))) begin
        if (BYPASS && write_onehot[i])
          val = wdata;
        else
          val = mem_q[i];
      end
    end
    return val;
  endfunction

  always_comb begin
    rdata1 = read_port(raddr1);
    rdata2 = read_port(raddr2);
  end

  // A write in the same cycle as clr_dirty survives the clear for its own bit.
  always_comb begin
    dirty_d = (clr_dirty ? '0 : dirty_q) | write_onehot;
    last_d  = (|write_onehot) ? write_onehot : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < REGNUM; i++) mem_q[i] <= '0;
    end else begin
      dirty_q <= dirty_d;
      last_q  <= last_d;
      for (int i = 0; i < REGNUM; i++) begin
        if (write_onehot[i]) mem_q[i] <= wdata;
      end
    end
  end

  assign dirty          = dirty_q;
  assign last_wr_onehot = last_q;

endmodule

// File: tb/tb_reg_file_decoded.sv
// Directed bench for reg_file_decoded: default configuration plus a
// REGNUM=16 / BYPASS=0 instance for range-drop and non-bypassed reads.
module tb_reg_file_decoded;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Instance A: defaults
  logic        rst_a, wen_a, clr_a;
  logic [4:0]  waddr_a, raddr1_a, raddr2_a;
  logic [31:0] wdata_a, rdata1_a, rdata2_a;
  logic [31:0] woh_a, last_a, dirty_a;

  // Instance B: REGNUM=16, BYPASS=0
  logic        rst_b, wen_b, clr_b;
  logic [4:0]  waddr_b, raddr1_b, raddr2_b;
  logic [31:0] wdata_b, rdata1_b, rdata2_b;
  logic [15:0] woh_b, last_b, dirty_b;

  reg_file_decoded u_a (
    .clk(clk), .rst(rst_a), .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a),
    .raddr1(raddr1_a), .raddr2(raddr2_a), .rdata1(rdata1_a), .rdata2(rdata2_a),
    .write_onehot(woh_a), .last_wr_onehot(last_a), .clr_dirty(clr_a), .dirty(dirty_a)
  );

  reg_file_decoded #(.REGNUM(16), .WIDTH(32), .KEY_LEN(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_b (
    .clk(clk), .rst(rst_b), .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b),
    .raddr1(raddr1_b), .raddr2(raddr2_b), .rdata1(rdata1_b), .rdata2(rdata2_b),
    .write_onehot(woh_b), .last_wr_onehot(last_b), .clr_dirty(clr_b), .dirty(dirty_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, then settle before sampling.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1; wen_a = 0; clr_a = 0; waddr_a = 0; wdata_a = 0; raddr1_a = 0; raddr2_a = 0;
    rst_b = 1; wen_b = 0; clr_b = 0; waddr_b = 0; wdata_b = 0; raddr1_b = 0; raddr2_b = 0;
    next_cycle();
    next_cycle();
    rst_a = 0; rst_b = 0;
    #1;

    // Reset state across every address
    chk("rst_dirty", dirty_a, 0);
    chk("rst_last", last_a, 0);
    chk("rst_woh", woh_a, 0);
    for (int a = 0; a < 32; a++) begin
      raddr1_a = a[4:0]; raddr2_a = 5'(31 - a);
      #1;
      chk($sformatf("rst_rd1_%0d", a), rdata1_a, 0);
      chk($sformatf("rst_rd2_%0d", 31 - a), rdata2_a, 0);
    end

    // Write reg 5 with same-cycle bypass
    next_cycle();
    wen_a = 1; waddr_a = 5; wdata_a = 32'hDEADBEEF; raddr1_a = 5; raddr2_a = 6;
    #1;
    chk("wr5_woh", woh_a, 32'h0000_0020);
    chk("wr5_byp_rd1", rdata1_a, 32'hDEADBEEF);
    chk("wr5_rd2_other", rdata2_a, 0);
    chk("wr5_dirty_pre", dirty_a, 0);
    next_cycle();
    wen_a = 0;
    #1;
    chk("wr5_dirty", dirty_a, 32'h0000_0020);
    chk("wr5_last", last_a, 32'h0000_0020);
    chk("wr5_rd1_stored", rdata1_a, 32'hDEADBEEF);
    chk("wr5_woh_idle", woh_a, 0);

    // Write to hardwired zero register is dropped
    next_cycle();
    wen_a = 1; waddr_a = 0; wdata_a = 32'hFFFFFFFF; raddr1_a = 0;
    #1;
    chk("wr0_woh", woh_a, 0);
    chk("wr0_rd1", rdata1_a, 0);
    next_cycle();
    wen_a = 0;
    #1;
    chk("wr0_rd1_next", rdata1_a, 0);
    chk("wr0_dirty", dirty_a, 32'h0000_0020);
    chk("wr0_last", last_a, 32'h0000_0020);

    // clr_dirty coinciding with a write to reg 31
    next_cycle();
    clr_a = 1; wen_a = 1; waddr_a = 31; wdata_a = 32'hA5A5A5A5; raddr1_a = 5; raddr2_a = 31;
    #1;
    chk("clrwr_woh", woh_a, 32'h8000_0000);
    chk("clrwr_byp_rd2", rdata2_a, 32'hA5A5A5A5);
    next_cycle();
    clr_a = 0; wen_a = 0;
    #1;
    chk("clrwr_dirty", dirty_a, 32'h8000_0000);
    chk("clrwr_last", last_a, 32'h8000_0000);
    chk("clrwr_rd1_reg5", rdata1_a, 32'hDEADBEEF);
    chk("clrwr_rd2_reg31", rdata2_a, 32'hA5A5A5A5);

    // clr_dirty alone: dirty clears, last and storage hold
    next_cycle();
    clr_a = 1;
    next_cycle();
    clr_a = 0; raddr1_a = 31; raddr2_a = 31;
    #1;
    chk("clr_dirty", dirty_a, 0);
    chk("clr_last", last_a, 32'h8000_0000);
    chk("same_addr_rd1", rdata1_a, 32'hA5A5A5A5);
    chk("same_addr_rd2", rdata2_a, 32'hA5A5A5A5);

    // Write coinciding with reset is discarded; bypass still visible during reset
    next_cycle();
    rst_a = 1; wen_a = 1; waddr_a = 3; wdata_a = 32'h12345678; raddr1_a = 3; raddr2_a = 5;
    #1;
    chk("rstwr_woh", woh_a, 32'h0000_0008);
    chk("rstwr_byp_rd1", rdata1_a, 32'h12345678);
    next_cycle();
    rst_a = 0; wen_a = 0;
    #1;
    chk("rstwr_rd1", rdata1_a, 0);
    chk("rstwr_rd2_reg5", rdata2_a, 0);
    chk("rstwr_dirty", dirty_a, 0);
    chk("rstwr_last", last_a, 0);

    // Instance B: out-of-range write dropped
    next_cycle();
    wen_b = 1; waddr_b = 20; wdata_b = 32'hCAFEF00D; raddr1_b = 20; raddr2_b = 4;
    #1;
    chk("b_oor_woh", woh_b, 0);
    chk("b_oor_rd1", rdata1_b, 0);
    next_cycle();
    wen_b = 1; waddr_b = 7; wdata_b = 32'h11111111; raddr1_b = 7;
    #1;
    chk("b_oor_dirty", dirty_b, 0);
    chk("b_oor_last", last_b, 0);
    chk("b_wr7_woh", woh_b, 16'h0080);
    chk("b_wr7_nobyp", rdata1_b, 0);
    next_cycle();
    wdata_b = 32'h22222222; raddr2_b = 7;
    #1;
    chk("b_wr7b_old_rd1", rdata1_b, 32'h11111111);
    chk("b_wr7b_old_rd2", rdata2_b, 32'h11111111);
    next_cycle();
    wen_b = 0;
    #1;
    chk("b_wr7b_new_rd1", rdata1_b, 32'h22222222);
    chk("b_dirty", dirty_b, 16'h0080);
    chk("b_last", last_b, 16'h0080);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file_decoded.md
REG_FILE_DECODED -- requirements
Module: reg_file_decoded

Interface
REQ-001 SHALL provide parameter REGNUM, default 32, number of architectural registers (2..2^KEY_LEN).
REQ-002 SHALL provide parameter WIDTH, default 32, bit width of each register.
REQ-003 SHALL provide parameter KEY_LEN, default 5, address width.
REQ-004 SHALL provide parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-005 SHALL provide parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding.
REQ-006 SHALL use a single clock and a synchronous, active-high reset on the ports below.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 wen  input  1  write request, sampled on rising clk.
REQ-010 waddr  input  KEY_LEN  write register index.
REQ-011 wdata  input  WIDTH  write data.
REQ-012 raddr1, raddr2  input  KEY_LEN  read register indices.
REQ-013 rdata1, rdata2  output  WIDTH  combinational read data.
REQ-014 write_onehot  output  REGNUM  combinational decoded write enables.
REQ-015 last_wr_onehot  output  REGNUM  registered one-hot of last committed write.
REQ-016 clr_dirty  input  1  clear dirty bitmap.
REQ-017 dirty  output  REGNUM  registered bitmap of registers written since reset/clear.

Function
REQ-018 write_onehot bit i SHALL be 1 iff wen=1, waddr=i, i<REGNUM, and not (ZERO_REG=1 and i=0); otherwise 0; at most one bit set.
REQ-019 A write SHALL commit on the rising clk edge where write_onehot is nonzero and rst=0; storage[waddr] takes wdata; visible to non-bypassed reads the next cycle.
REQ-020 Writes with waddr>=REGNUM, or to register 0 with ZERO_REG=1, SHALL be dropped with no state change (storage, dirty, last_wr_onehot unchanged).
REQ-021 rdataN SHALL equal 0 when raddrN>=REGNUM or (ZERO_REG=1 and raddrN=0).
REQ-022 With BYPASS=1, rdataN SHALL equal wdata when write_onehot[raddrN]=1 in the same cycle; otherwise storage[raddrN].
REQ-023 With BYPASS=0, rdataN SHALL always equal storage[raddrN] (old value during same-cycle write).
REQ-024 Both read ports SHALL operate independently; equal addresses return identical data.
REQ-025 last_wr_onehot SHALL load write_onehot on each committed write and hold otherwise.
REQ-026 dirty[i] SHALL set on a committed write to i; clr_dirty=1 SHALL clear all bits at the next edge.
REQ-027 clr_dirty and a committed write in the same cycle SHALL leave dirty equal to write_onehot (write wins for its bit, all others cleared).
REQ-028 Latency: write-to-storage 1 cycle; read 0 cycles (combinational).

Reset
REQ-029 On rising clk with rst=1, all storage, dirty and last_wr_onehot SHALL become 0.
REQ-030 rst SHALL take priority over wen and clr_dirty; a write coinciding with rst SHALL be discarded.
REQ-031 write_onehot and bypass SHALL remain combinational during rst (not gated by rst); rdata shows bypassed wdata if selected, else 0 after reset.

Verification
REQ-032 Reset then read all addresses -> rdata1=rdata2=0, dirty=0, last_wr_onehot=0.
REQ-033 wen=1, waddr=5, wdata=32'hDEADBEEF, raddr1=5 -> write_onehot=32'h00000020, rdata1=32'hDEADBEEF same cycle (BYPASS=1); next cycle dirty=32'h00000020, last_wr_onehot=32'h00000020, rdata1 stays 32'hDEADBEEF with wen=0.
REQ-034 wen=1, waddr=0, wdata=32'hFFFFFFFF (ZERO_REG=1) -> write_onehot=0, rdata(0)=0 same and next cycle, dirty unchanged.
REQ-035 dirty=32'h00000020, same cycle clr_dirty=1 and write reg 31 -> next cycle dirty=32'h80000000, last_wr_onehot=32'h80000000.
REQ-036 rst=1 with wen=1, waddr=3, wdata=32'h12345678 -> next cycle rdata(3)=0, dirty=0.
REQ-037 REGNUM=16, KEY_LEN=5, BYPASS=0: write to waddr=20 -> write_onehot=0, dropped; write reg 7 with raddr1=7 -> rdata1 old value same cycle, new value next cycle.
